client_accum_ram: RTL and testbench
===================================

CLIENT_ACCUM_RAM -- requirements
Module: client_accum_ram

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 32, the width of each per-client accumulated value.
REQ-002 The block SHALL have parameter A_WIDTH, default 5, the client-ID (address) width.
REQ-003 The block SHALL have parameter A_MAX, default 2**A_WIDTH, the entry count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports acc_valid (input, 1), acc_ready (output, 1), acc_addr (input, A_WIDTH) and acc_data (input, D_WIDTH): the accumulate request, where acc_addr is the client ID and acc_data is the cancelled-order value to add.
REQ-007 The block SHALL have ports rd_en (input, 1), rd_addr (input, A_WIDTH), rd_data (output, D_WIDTH) and rd_valid (output, 1): the read port.
REQ-008 The block SHALL have ports clr_start (input, 1), busy (output, 1) and overflow (output, 1): the clear-all request, clear/init in progress, and the sticky overflow flag.

Function
REQ-009 The FSM SHALL have states INIT (zeroing after reset), RUN and CLEAR (zeroing on request); busy SHALL be 1 in INIT and CLEAR, else 0.
REQ-010 In INIT/CLEAR a sweep counter SHALL write 0 to entries 0..A_MAX-1, one per cycle, then go to RUN; sweep length SHALL be exactly A_MAX cycles.
REQ-011 acc_ready SHALL equal (state==RUN) && !clr_start; an accumulation SHALL be accepted on an edge where acc_valid && acc_ready.
REQ-012 The accumulate path SHALL be two stages: the acceptance edge registers addr, data and memory[addr]; the next edge writes memory[addr] = old + data.
REQ-013 Back-to-back accumulations to the same address SHALL forward the stage-2 sum into stage 1, so N accepted adds of v to address a yield exactly N*v (modulo the overflow rule).
REQ-014 rd_en SHALL be honoured only in RUN; rd_data/rd_valid SHALL update one edge after rd_en is sampled (latency 1); rd_valid SHALL be 0 on cycles without an honoured read.
REQ-015 A read sampled on the same edge as a stage-2 write to the same address SHALL return the new sum, so an accumulation accepted at edge E is visible to any read sampled at edge E+1 or later.
REQ-016 The sum SHALL be computed at D_WIDTH+1 bits; if the carry bit is set, overflow SHALL set and remain set until reset or clear.
REQ-017 clr_start SHALL be honoured only in RUN; while busy it SHALL be ignored.
REQ-018 On entering CLEAR, any in-flight stage-2 accumulation SHALL be discarded; the sweep write SHALL have priority.
REQ-019 Entering CLEAR SHALL clear overflow.
REQ-020 Simultaneous acc_valid and clr_start SHALL accept no accumulation, because clear wins.

Reset
REQ-021 Asserting reset SHALL immediately force state INIT, sweep counter 0, pipeline valid 0, acc_ready 0, busy 1, rd_valid 0, rd_data 0 and overflow 0.
REQ-022 Reset asserted mid-accumulate or mid-sweep SHALL discard all in-flight work and restart the full A_MAX-cycle sweep after deassertion.

Configuration
REQ-023 With ACCUM_SATURATE_EN defined, an overflowing sum SHALL write all-ones (2**D_WIDTH-1) to the entry and set overflow.
REQ-024 Without ACCUM_SATURATE_EN, an overflowing sum SHALL wrap modulo 2**D_WIDTH and set overflow.

Verification
REQ-025 Reset release with defaults: busy=1 for exactly 32 cycles, acc_ready=1 after; read of every address returns 0, overflow=0.
REQ-026 Five consecutive accepted adds of 7 to address 3, then a read of 3 on the following edge: rd_data=35 with rd_valid one cycle later (forwarding check).
REQ-027 Add 5 to address 9; read address 9 sampled on the very next edge: rd_data=5.
REQ-028 Address 1 holds 0xFFFFFFF0, then add 0x20: without the macro rd_data=0x00000010 and overflow=1; with ACCUM_SATURATE_EN rd_data=0xFFFFFFFF and overflow=1.
REQ-029 acc_valid and clr_start asserted on the same edge with an accumulation in stage 2: acc_ready=0, busy=1 for 32 cycles, all entries read 0, overflow=0.
REQ-030 Reset pulsed during CLEAR at sweep count 10: the full 32-cycle INIT sweep restarts and no accumulation is accepted until busy=0.

Source files
------------

// File: rtl/client_accum_ram.sv
// Per-client accumulator RAM with a forwarded two-stage read-modify-write, zeroing sweeps and a
// sticky overflow flag. Define ACCUM_SATURATE_EN to saturate overflowing sums instead of wrapping.
module client_accum_ram #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 2**A_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [A_WIDTH-1:0] acc_addr,
    input  logic [D_WIDTH-1:0] acc_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    input  logic               clr_start,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {INIT, RUN, CLEAR} state_e;

    localparam logic [A_WIDTH-1:0] SWEEP_LAST = A_WIDTH'(A_MAX - 1);

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] sweep_q, sweep_d;
    logic               p_valid_q, p_valid_d;
    logic [A_WIDTH-1:0] p_addr_q, p_addr_d;
    logic [D_WIDTH-1:0] p_data_q, p_data_d;
    logic [D_WIDTH-1:0] p_old_q, p_old_d;
    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ovf_q, ovf_d;

    logic [D_WIDTH-1:0] mem [A_MAX];

    logic               running, clr_go, acc_go, s2_we;
    logic [D_WIDTH:0]   sum;
    logic [D_WIDTH-1:0] wr_val;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [D_WIDTH-1:0] mem_wdata;

    always_comb begin
        running = (state_q == RUN);
        clr_go  = running && clr_start;
        acc_go  = running && acc_valid && !clr_start;
        // A clear accepted on this edge discards the stage-2 write in flight.
        s2_we   = running && p_valid_q && !clr_start;
        sum     = {1'b0, p_old_q} + {1'b0, p_data_q};
`ifdef ACCUM_SATURATE_EN
        wr_val  = sum[D_WIDTH] ? '1 : sum[D_WIDTH-1:0];
`else
        wr_val  = sum[D_WIDTH-1:0];
`endif
    end

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        p_valid_d  = acc_go;
        p_addr_d   = p_addr_q;
        p_data_d   = p_data_q;
        p_old_d    = p_old_q;
        rd_valid_d = running && rd_en;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = sweep_q;
        mem_wdata  = '0;

        case (state_q)
            RUN: begin
                if (s2_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = p_addr_q;
                    mem_wdata = wr_val;
                    if (sum[D_WIDTH]) ovf_d = 1'b1;
                end
                // The sum being written this edge is newer than the array contents.
                if (acc_go) begin
                    p_addr_d = acc_addr;
                    p_data_d = acc_data;
                    p_old_d  = (s2_we && p_addr_q == acc_addr) ? wr_val : mem[acc_addr];
                end
                if (rd_en) begin
                    rd_data_d = (s2_we && p_addr_q == rd_addr) ? wr_val : mem[rd_addr];
                end
                if (clr_go) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                mem_we  = 1'b1;
                sweep_d = sweep_q + A_WIDTH'(1);
                if (sweep_q == SWEEP_LAST) begin
                    sweep_d = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            p_valid_q  <= 1'b0;
            p_addr_q   <= '0;
            p_data_q   <= '0;
            p_old_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            p_valid_q  <= p_valid_d;
            p_addr_q   <= p_addr_d;
            p_data_q   <= p_data_d;
            p_old_q    <= p_old_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: the array has no reset; the INIT sweep zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign acc_ready = running && !clr_start;
    assign busy      = (state_q != RUN);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_client_accum_ram.sv
// Randomized and directed bench for client_accum_ram against an array-based reference model.
module tb_client_accum_ram;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int AM = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clr_start;
    logic          busy;
    logic          overflow;

    always #5 clk = ~clk;

    client_accum_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_addr  (acc_addr),
        .acc_data  (acc_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy),
        .overflow  (overflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: an accumulation is applied to the array the moment it is accepted.
    logic [DW-1:0] model [AM];
    bit            model_ovf;
    int            sweep_left;
    bit            exp_rd_valid;
    logic [DW-1:0] exp_rd_data;
    bit            last_acc;

    task automatic model_reset();
        for (int i = 0; i < AM; i++) model[i] = '0;
        model_ovf    = 1'b0;
        sweep_left   = AM;
        exp_rd_valid = 1'b0;
        exp_rd_data  = '0;
        last_acc     = 1'b0;
    endtask

    task automatic model_add(input logic [AW-1:0] a, input logic [DW-1:0] d);
        longint s;
        longint maxv;
        maxv = (longint'(1) << DW) - 1;
        s    = longint'(model[a]) + longint'(d);
        if (s > maxv) begin
            model_ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
            s = maxv;
`else
            s = s - (maxv + 1);
`endif
        end
        model[a] = DW'(s);
    endtask

    // Advance one clock edge and update the model with what the DUT should have done on it.
    task automatic tick();
        bit            run, do_clr, do_acc, do_rd;
        logic [AW-1:0] aa, ra;
        logic [DW-1:0] ad;
        run    = (sweep_left == 0);
        do_clr = run && clr_start;
        do_acc = run && acc_valid && !clr_start;
        do_rd  = run && rd_en;
        aa = acc_addr;
        ad = acc_data;
        ra = rd_addr;
        @(posedge clk);
        #1;
        exp_rd_valid = do_rd;
        if (do_rd) exp_rd_data = model[ra];
        if (sweep_left > 0) sweep_left--;
        last_acc = do_acc;
        if (do_clr) begin
            for (int i = 0; i < AM; i++) model[i] = '0;
            model_ovf  = 1'b0;
            sweep_left = AM;
        end else if (do_acc) begin
            model_add(aa, ad);
        end
    endtask

    task automatic idle_inputs();
        acc_valid = 1'b0;
        acc_addr  = '0;
        acc_data  = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        clr_start = 1'b0;
    endtask

    task automatic run_until_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (acc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", acc_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_until_idle(n);
        total++; if (n != AM) begin bad++; $display("FAIL init_sweep_len: got %0d want %0d", n, AM); end
        total++; if (acc_ready !== 1'b1) begin bad++; $display("FAIL ready_after_init: got %b want 1", acc_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_after_init: got %b want 0", overflow); end
    endtask

    task automatic test_read_all();
        for (int i = 0; i < AM; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            tick();
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read_all_valid[%0d]: got %b want 1", i, rd_valid); end
            total++; if (rd_data !== exp_rd_data) begin bad++; $display("FAIL read_all_data[%0d]: got %0h want %0h", i, rd_data, exp_rd_data); end
        end
        rd_en = 1'b0;
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_idle_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_forward();
        acc_valid = 1'b1;
        acc_addr  = AW'(3);
        acc_data  = DW'(7);
        repeat (5) tick();
        acc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = AW'(3);
        tick();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid: got %b want 1", rd_valid); end
        total++; if (rd_data !== DW'(35)) begin bad++; $display("FAIL fwd_sum: got %0d want 35", rd_data); end
    endtask

    task automatic test_read_after_write();
        acc_valid = 1'b1;
        acc_addr  = AW'(9);
        acc_data  = DW'(5);
        tick();
        acc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = AW'(9);
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== DW'(5)) begin bad++; $display("FAIL raw_next_edge: got %0d want 5", rd_data); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL raw_valid: got %b want 1", rd_valid); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] want;
`ifdef ACCUM_SATURATE_EN
        want = 32'hFFFF_FFFF;
`else
        want = 32'h0000_0010;
`endif
        acc_valid = 1'b1;
        acc_addr  = AW'(1);
        acc_data  = 32'hFFFF_FFF0;
        tick();
        acc_valid = 1'b0;
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", overflow); end
        acc_valid = 1'b1;
        acc_data  = 32'h0000_0020;
        tick();
        acc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = AW'(1);
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== want) begin bad++; $display("FAIL ovf_value: got %0h want %0h", rd_data, want); end
        total++; if (rd_data !== exp_rd_data) begin bad++; $display("FAIL ovf_model: got %0h want %0h", rd_data, exp_rd_data); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    endtask

    task automatic test_clear_collision();
        int n;
        acc_valid = 1'b1;
        acc_addr  = AW'(4);
        acc_data  = DW'(11);
        tick();
        clr_start = 1'b1;
        #1;
        total++; if (acc_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", acc_ready); end
        tick();
        clr_start = 1'b0;
        acc_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy: got %b want 1", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf: got %b want 0", overflow); end
        run_until_idle(n);
        total++; if (n != AM) begin bad++; $display("FAIL clr_sweep_len: got %0d want %0d", n, AM); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int ready_bad;
        acc_valid = 1'b1;
        acc_addr  = AW'(2);
        acc_data  = DW'(9);
        tick();
        acc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = AW'(2);
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== DW'(9)) begin bad++; $display("FAIL pre_clear_read: got %0d want 9", rd_data); end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (10) tick();
        acc_valid = 1'b1;
        acc_addr  = AW'(6);
        acc_data  = DW'(3);
        reset     = 1'b1;
        model_reset();
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
        total++; if (acc_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got %b want 0", acc_ready); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_mid_rd_data: got %0h want 0", rd_data); end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        n         = 0;
        ready_bad = 0;
        while (busy === 1'b1 && n < 200) begin
            if (acc_ready !== 1'b0) ready_bad++;
            tick();
            n++;
        end
        total++; if (n != AM) begin bad++; $display("FAIL rst_mid_sweep_len: got %0d want %0d", n, AM); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL rst_mid_ready_busy: got %0d cycles ready want 0", ready_bad); end
        tick();
        acc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = AW'(6);
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== exp_rd_data || exp_rd_data !== DW'(3)) begin
            bad++; $display("FAIL rst_mid_single_acc: got %0d want 3", rd_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            acc_valid = ($urandom_range(0, 3) != 0);
            acc_addr  = AW'($urandom_range(0, 3));
            acc_data  = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 1000));
            rd_en     = ($urandom_range(0, 1) == 1);
            rd_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, AM - 1)) : AW'($urandom_range(0, 3));
            clr_start = ($urandom_range(0, 99) == 0);
            #1;
            total++; if (acc_ready !== (sweep_left == 0 && !clr_start)) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", it, acc_ready, sweep_left == 0 && !clr_start);
            end
            tick();
            total++; if (busy !== (sweep_left > 0)) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", it, busy, sweep_left > 0); end
            total++; if (rd_valid !== exp_rd_valid) begin bad++; $display("FAIL rnd_rd_valid[%0d]: got %b want %b", it, rd_valid, exp_rd_valid); end
            if (exp_rd_valid) begin
                total++; if (rd_data !== exp_rd_data) begin bad++; $display("FAIL rnd_rd_data[%0d]: got %0h want %0h", it, rd_data, exp_rd_data); end
            end
            if (!last_acc) begin
                total++; if (overflow !== model_ovf) begin bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", it, overflow, model_ovf); end
            end
        end
        idle_inputs();
        tick();
        tick();
        total++; if (overflow !== model_ovf) begin bad++; $display("FAIL rnd_ovf_end: got %b want %b", overflow, model_ovf); end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_forward();
        test_read_after_write();
        test_overflow();
        test_clear_collision();
        test_read_all();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
